// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, WB->ID bypass, load-use stall, branch flush, freeze.
// Control outputs are combinational; shadow state and counters update on the rising edge.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             id_regrt,
    input  logic             ex_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             flush,
    output logic             idex_bubble,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [5:0] OP_ALUOP = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef enum logic [1:0] {ACT_HOLD, ACT_FLUSH, ACT_STALL, ACT_RUN} act_t;

    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       uses_rs, uses_rt;

    logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
    logic       mem_eff, wb_eff, load_use;
    act_t       act;

    // Shift amount, low func bits and the MEM load flag carry no hazard information.
    logic unused_bits;
    assign unused_bits = ^{id_instr[10:6], id_instr[1:0], mem_m2reg};

    assign id_op  = id_instr[31:26];
    assign id_rs  = id_instr[25:21];
    assign id_rt  = id_instr[20:16];
    assign id_dst = id_regrt ? id_rt : id_instr[15:11];

    assign uses_rs = !((id_op == OP_ALUOP) && (id_instr[5:2] == 4'd0));
    assign uses_rt = (id_op == OP_ALUOP) || (id_op == OP_SW) || (id_op == OP_BEQ);

    assign mem_eff = mem_wreg && (mem_dst != 5'd0);
    assign wb_eff  = wb_wreg && (wb_dst != 5'd0);

    assign load_use = ex_wreg && ex_m2reg && (ex_dst != 5'd0) &&
                      ((uses_rs && (ex_dst == id_rs)) || (uses_rt && (ex_dst == id_rt)));

    always_comb begin
        act = ACT_RUN;
        if (mem_busy)      act = ACT_HOLD;
        else if (ex_taken) act = ACT_FLUSH;
        else if (load_use) act = ACT_STALL;
    end

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        flush       = 1'b0;
        idex_bubble = 1'b1;
        stall       = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        id_byp_a    = 1'b0;
        id_byp_b    = 1'b0;
        if (rst) begin
            idex_bubble = 1'b0;
            case (act)
                ACT_FLUSH: begin
                    flush       = 1'b1;
                    idex_bubble = 1'b1;
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                end
                ACT_STALL: begin
                    stall       = 1'b1;
                    idex_bubble = 1'b1;
                end
                ACT_RUN: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
                default: ;
            endcase
            // The newer result in MEM takes precedence over WB.
            if (mem_eff && (mem_dst == ex_rs))     fwd_a = 2'b01;
            else if (wb_eff && (wb_dst == ex_rs))  fwd_a = 2'b10;
            if (mem_eff && (mem_dst == ex_rt))     fwd_b = 2'b01;
            else if (wb_eff && (wb_dst == ex_rt))  fwd_b = 2'b10;
            id_byp_a = wb_eff && (wb_dst == id_rs);
            id_byp_b = wb_eff && (wb_dst == id_rt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dst    <= '0;
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            mem_dst   <= '0;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            wb_dst    <= '0;
            wb_wreg   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (act != ACT_HOLD) begin
            mem_dst   <= ex_dst;
            mem_wreg  <= ex_wreg;
            mem_m2reg <= ex_m2reg;
            wb_dst    <= mem_dst;
            wb_wreg   <= mem_wreg;
            if (act == ACT_RUN) begin
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_dst   <= id_dst;
                ex_wreg  <= id_wreg;
                ex_m2reg <= id_m2reg;
            end else begin
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_dst   <= '0;
                ex_wreg  <= 1'b0;
                ex_m2reg <= 1'b0;
            end
            if ((act == ACT_FLUSH) && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if ((act == ACT_STALL) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; counters run narrow so saturation is reachable quickly.
module tb_hazard_ctrl;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   id_instr;
    logic          id_wreg, id_m2reg, id_regrt, ex_taken, mem_busy;
    logic          pc_we, ifid_we, flush, idex_bubble, stall;
    logic [1:0]    fwd_a, fwd_b;
    logic          id_byp_a, id_byp_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_regrt(id_regrt), .ex_taken(ex_taken), .mem_busy(mem_busy), .pc_we(pc_we),
        .ifid_we(ifid_we), .flush(flush), .idex_bubble(idex_bubble), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic          pc_we;
        logic          ifid_we;
        logic          flush;
        logic          idex_bubble;
        logic          stall;
        logic [1:0]    fwd_a;
        logic [1:0]    fwd_b;
        logic          id_byp_a;
        logic          id_byp_b;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } obs_t;

    obs_t exp_q[$];
    obs_t last;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference pipeline state
    logic [4:0]    m_ex_rs, m_ex_rt, m_ex_dst, m_mem_dst, m_wb_dst;
    logic          m_ex_wreg, m_ex_m2reg, m_mem_wreg, m_wb_wreg;
    logic [CW-1:0] m_scnt, m_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_ex_rs, m_ex_rt, m_ex_dst, m_mem_dst, m_wb_dst} = '0;
        {m_ex_wreg, m_ex_m2reg, m_mem_wreg, m_wb_wreg} = '0;
        m_scnt = '0;
        m_fcnt = '0;
    endtask

    function automatic logic hazard_now();
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       u_rs, u_rt;
        op   = id_instr[31:26];
        rs   = id_instr[25:21];
        rt   = id_instr[20:16];
        u_rs = !(op == 6'h00 && id_instr[5:2] == 4'h0);
        u_rt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
        return m_ex_wreg && m_ex_m2reg && (m_ex_dst != 0) &&
               ((u_rs && m_ex_dst == rs) || (u_rt && m_ex_dst == rt));
    endfunction

    function automatic logic [1:0] sel(input logic [4:0] src);
        if (m_mem_wreg && m_mem_dst != 0 && m_mem_dst == src) return 2'b01;
        if (m_wb_wreg && m_wb_dst != 0 && m_wb_dst == src)    return 2'b10;
        return 2'b00;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o = '0;
        if (mem_busy) begin
        end else if (ex_taken) begin
            o.flush = 1; o.idex_bubble = 1; o.pc_we = 1; o.ifid_we = 1;
        end else if (hazard_now()) begin
            o.stall = 1; o.idex_bubble = 1;
        end else begin
            o.pc_we = 1; o.ifid_we = 1;
        end
        o.fwd_a     = sel(m_ex_rs);
        o.fwd_b     = sel(m_ex_rt);
        o.id_byp_a  = m_wb_wreg && m_wb_dst != 0 && m_wb_dst == id_instr[25:21];
        o.id_byp_b  = m_wb_wreg && m_wb_dst != 0 && m_wb_dst == id_instr[20:16];
        o.stall_cnt = m_scnt;
        o.flush_cnt = m_fcnt;
        return o;
    endfunction

    task automatic model_clock();
        logic lu;
        lu = hazard_now();
        if (mem_busy) return;
        m_wb_dst   = m_mem_dst;
        m_wb_wreg  = m_mem_wreg;
        m_mem_dst  = m_ex_dst;
        m_mem_wreg = m_ex_wreg;
        if (ex_taken || lu) begin
            {m_ex_rs, m_ex_rt, m_ex_dst, m_ex_wreg, m_ex_m2reg} = '0;
            if (ex_taken) begin
                if (m_fcnt != {CW{1'b1}}) m_fcnt = m_fcnt + 1;
            end else if (m_scnt != {CW{1'b1}}) m_scnt = m_scnt + 1;
        end else begin
            m_ex_rs    = id_instr[25:21];
            m_ex_rt    = id_instr[20:16];
            m_ex_dst   = id_regrt ? id_instr[20:16] : id_instr[15:11];
            m_ex_wreg  = id_wreg;
            m_ex_m2reg = id_m2reg;
        end
    endtask

    // Called just after a rising edge; compares on the falling edge.
    task automatic step(input logic [31:0] ins, input logic w, input logic m, input logic r,
                        input logic tk = 1'b0, input logic bz = 1'b0);
        obs_t e;
        id_instr = ins; id_wreg = w; id_m2reg = m; id_regrt = r;
        ex_taken = tk;  mem_busy = bz;
        exp_q.push_back(model_out());
        @(negedge clk);
        last = '{pc_we, ifid_we, flush, idex_bubble, stall, fwd_a, fwd_b,
                 id_byp_a, id_byp_b, stall_cnt, flush_cnt};
        e = exp_q.pop_front();
        chk("pc_we", last.pc_we, e.pc_we);
        chk("ifid_we", last.ifid_we, e.ifid_we);
        chk("flush", last.flush, e.flush);
        chk("idex_bubble", last.idex_bubble, e.idex_bubble);
        chk("stall", last.stall, e.stall);
        chk("fwd_a", last.fwd_a, e.fwd_a);
        chk("fwd_b", last.fwd_b, e.fwd_b);
        chk("id_byp_a", last.id_byp_a, e.id_byp_a);
        chk("id_byp_b", last.id_byp_b, e.id_byp_b);
        chk("stall_cnt", last.stall_cnt, e.stall_cnt);
        chk("flush_cnt", last.flush_cnt, e.flush_cnt);
        model_clock();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic add_i(input logic [4:0] rd, rs, rt, input logic tk = 1'b0);
        step(r_ins(rs, rt, rd, 5'd0, 6'h20), 1'b1, 1'b0, 1'b0, tk);
    endtask
    task automatic lw_i(input logic [4:0] rt, rs);
        step(i_ins(6'h23, rs, rt), 1'b1, 1'b1, 1'b1);
    endtask
    task automatic sll_i(input logic [4:0] rd, rs, rt);
        step(r_ins(rs, rt, rd, 5'd2, 6'h00), 1'b1, 1'b0, 1'b0);
    endtask
    task automatic nop_i(input logic tk = 1'b0, input logic bz = 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b0, tk, bz);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_we"}, pc_we, 0);
        chk({tag, "_ifid_we"}, ifid_we, 0);
        chk({tag, "_bubble"}, idex_bubble, 1);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fwd"}, {fwd_a, fwd_b}, 0);
        chk({tag, "_byp"}, {id_byp_a, id_byp_b}, 0);
        chk({tag, "_scnt"}, stall_cnt, 0);
        chk({tag, "_fcnt"}, flush_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] fc0, sc0;
        rst = 1'b0;
        id_instr = i_ins(6'h23, 5'd1, 5'd3);
        {id_wreg, id_m2reg, id_regrt, ex_taken, mem_busy} = 5'b11100;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst = 1'b1;

        // Back-to-back and one-apart ALU dependencies
        add_i(5'd3, 5'd1, 5'd2);
        add_i(5'd4, 5'd3, 5'd5);
        nop_i();
        chk("alu_b2b_fwd_a", last.fwd_a, 2'b01);
        chk("alu_b2b_stall", last.stall, 0);
        add_i(5'd3, 5'd1, 5'd2);
        step(i_ins(6'h08, 5'd1, 5'd9), 1'b1, 1'b0, 1'b1);
        add_i(5'd4, 5'd3, 5'd5);
        nop_i();
        chk("alu_gap_fwd_a", last.fwd_a, 2'b10);

        // Load-use: one stall, then forward from WB on both operands
        lw_i(5'd3, 5'd0);
        add_i(5'd4, 5'd3, 5'd3);
        chk("lu_stall", last.stall, 1);
        chk("lu_pc_we", last.pc_we, 0);
        chk("lu_bubble", last.idex_bubble, 1);
        add_i(5'd4, 5'd3, 5'd3);
        chk("lu_release", last.stall, 0);
        nop_i();
        chk("lu_fwd", {last.fwd_a, last.fwd_b}, 4'b1010);
        chk("lu_scnt", last.stall_cnt, 1);

        // Register zero and shift rs handling
        add_i(5'd0, 5'd1, 5'd2);
        add_i(5'd4, 5'd0, 5'd0);
        nop_i();
        chk("r0_fwd", {last.fwd_a, last.fwd_b}, 4'b0000);
        lw_i(5'd3, 5'd1);
        sll_i(5'd4, 5'd0, 5'd3);
        chk("sll_rt_stall", last.stall, 1);
        sll_i(5'd4, 5'd0, 5'd3);
        lw_i(5'd5, 5'd1);
        sll_i(5'd4, 5'd5, 5'd3);
        chk("sll_rs_nostall", last.stall, 0);

        // Taken branch beats load-use; freeze beats branch
        lw_i(5'd3, 5'd1);
        fc0 = m_fcnt;
        sc0 = m_scnt;
        add_i(5'd4, 5'd3, 5'd3, 1'b1);
        chk("tk_flush", last.flush, 1);
        chk("tk_stall", last.stall, 0);
        nop_i(1'b1, 1'b1);
        chk("busy_pc_we", last.pc_we, 0);
        chk("busy_flush", last.flush, 0);
        nop_i();
        chk("tk_fcnt", last.flush_cnt, fc0 + 1'b1);
        chk("tk_scnt", last.stall_cnt, sc0);

        // WB to ID bypass
        lw_i(5'd7, 5'd1);
        nop_i();
        nop_i();
        add_i(5'd8, 5'd7, 5'd1);
        chk("byp_a", last.id_byp_a, 1);
        lw_i(5'd0, 5'd1);
        nop_i();
        nop_i();
        add_i(5'd8, 5'd0, 5'd1);
        chk("byp_r0", last.id_byp_a, 0);

        // Saturating stall counter: alternating stall / refill cycles
        for (int i = 0; i < 2 * (1 << CW) + 8; i++) begin
            step(i_ins(6'h23, 5'd3, 5'd3), 1'b1, 1'b1, 1'b1);
        end
        nop_i();
        chk("sat_scnt", last.stall_cnt, {CW{1'b1}});

        // Asynchronous reset in the middle of a load-use stall
        lw_i(5'd3, 5'd1);
        id_instr = r_ins(5'd3, 5'd3, 5'd4, 5'd0, 6'h20);
        {id_wreg, id_m2reg, id_regrt} = 3'b100;
        #2;
        chk("pre_rst_stall", stall, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        nop_i();
        chk("post_rst_pc_we", last.pc_we, 1);
        chk("post_rst_scnt", last.stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
